// File: rtl/rotate_arbiter_if.sv
// Request/grant bundle between a set of requesters and rotate_arbiter.
//   master : drives requests/accept/last/prio_load/prio_in, observes grant side
//   slave  : the arbiter; drives grants/grant_valid/grant_id/prio/locked
interface rotate_arbiter_if #(
  parameter int SIZE = 4,
  parameter int PW   = (SIZE > 2) ? $clog2(SIZE) : 1
);
  logic [SIZE-1:0] requests;
  logic            accept;
  logic            last;
  logic            prio_load;
  logic [PW-1:0]   prio_in;
  logic [SIZE-1:0] grants;
  logic            grant_valid;
  logic [PW-1:0]   grant_id;
  logic [PW-1:0]   prio;
  logic            locked;

  modport master (
    output requests, accept, last, prio_load, prio_in,
    input  grants, grant_valid, grant_id, prio, locked
  );
  modport slave (
    input  requests, accept, last, prio_load, prio_in,
    output grants, grant_valid, grant_id, prio, locked
  );
endinterface

// File: rtl/rotate_arbiter.sv
// Round-robin arbiter with a registered rotating priority pointer and an
// optional packet lock that holds the grant until a last beat is accepted.
//   clock, reset_n : rising-edge clock, async active-low reset
//   bus (slave)    : requests/accept/last/prio_load/prio_in in,
//                    grants/grant_valid/grant_id/prio/locked out
// Grant outputs are purely combinational from requests and state.
module rotate_arbiter #(
  parameter int SIZE = 4,
  parameter int LOCK = 1,
  parameter int PW   = (SIZE > 2) ? $clog2(SIZE) : 1
) (
  input  logic           clock,
  input  logic           reset_n,
  rotate_arbiter_if.slave bus
);
  logic [PW-1:0]   prio_q, lock_id_q;
  logic            locked_q;
  logic [SIZE-1:0] hi_mask, req_hi, pick, gnt;
  logic [PW-1:0]   gnt_id, prio_inc;
  logic            gnt_vld, acc, done, lock_set, lock_clr, load_ok;

  // Lanes at or above the pointer form the first search window; if none of
  // them request, the wrapped window is simply the lowest set request.
  for (genvar g = 0; g < SIZE; g++) begin : g_lane
    assign hi_mask[g] = (PW'(g) >= prio_q);
  end

  assign req_hi = bus.requests & hi_mask;
  assign pick   = (|req_hi) ? req_hi : bus.requests;

  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    if (locked_q) begin
      // Only the lock owner may be granted, even when it has dropped out.
      for (int i = 0; i < SIZE; i++)
        if (lock_id_q == PW'(i)) gnt[i] = bus.requests[i];
      gnt_id = (|gnt) ? lock_id_q : '0;
    end else begin
      // Descending scan so the lowest set bit of pick wins.
      for (int i = SIZE - 1; i >= 0; i--)
        if (pick[i]) begin
          gnt    = '0;
          gnt[i] = 1'b1;
          gnt_id = PW'(i);
        end
    end
  end

  assign gnt_vld  = |gnt;
  assign acc      = gnt_vld & bus.accept;
  assign done     = acc & ((LOCK == 0) | bus.last);
  assign lock_set = (LOCK != 0) && acc && !bus.last && !locked_q;
  assign lock_clr = locked_q && done;
  assign prio_inc = (gnt_id == PW'(SIZE - 1)) ? '0 : gnt_id + 1'b1;
  assign load_ok  = bus.prio_load && ({1'b0, bus.prio_in} < (PW+1)'(SIZE));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prio_q    <= '0;
      locked_q  <= 1'b0;
      lock_id_q <= '0;
    end else begin
      // An explicit load beats the post-grant advance.
      if (load_ok)   prio_q <= bus.prio_in;
      else if (done) prio_q <= prio_inc;
      if (lock_set) begin
        locked_q  <= 1'b1;
        lock_id_q <= gnt_id;
      end else if (lock_clr) begin
        locked_q  <= 1'b0;
      end
    end
  end

  assign bus.grants      = gnt;
  assign bus.grant_valid = gnt_vld;
  assign bus.grant_id    = gnt_id;
  assign bus.prio        = prio_q;
  assign bus.locked      = locked_q;
endmodule

// File: tb/tb_rotate_arbiter.sv
module tb_rotate_arbiter;
  logic clock = 1'b0;
  logic reset_n;
  int   nchk = 0, nerr = 0;

  always #5 clock = ~clock;

  rotate_arbiter_if #(.SIZE(4)) b0 ();
  rotate_arbiter_if #(.SIZE(4)) b1 ();
  rotate_arbiter_if #(.SIZE(5)) b2 ();

  rotate_arbiter #(.SIZE(4), .LOCK(0)) u0 (.clock(clock), .reset_n(reset_n), .bus(b0));
  rotate_arbiter #(.SIZE(4), .LOCK(1)) u1 (.clock(clock), .reset_n(reset_n), .bus(b1));
  rotate_arbiter #(.SIZE(5), .LOCK(0)) u2 (.clock(clock), .reset_n(reset_n), .bus(b2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Drive at the falling edge, sample 1 time unit later.
  task automatic step();
    @(negedge clock);
  endtask

  initial begin
    reset_n = 1'b0;
    {b0.requests, b0.accept, b0.last, b0.prio_load, b0.prio_in} = '0;
    {b1.requests, b1.accept, b1.last, b1.prio_load, b1.prio_in} = '0;
    {b2.requests, b2.accept, b2.last, b2.prio_load, b2.prio_in} = '0;
    #12;
    chk("rst_grants", 32'(b0.grants), 0);
    chk("rst_gvld",   32'(b0.grant_valid), 0);
    chk("rst_gid",    32'(b0.grant_id), 0);
    chk("rst_prio",   32'(b0.prio), 0);
    chk("rst_locked", 32'(b1.locked), 0);
    b0.requests = 4'b0100;
    #1 chk("rst_follow", 32'(b0.grants), 32'h4);
    b0.requests = '0;

    // Full-request rotation, LOCK=0
    step(); reset_n = 1'b1;
    b0.requests = 4'b1111; b0.accept = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk($sformatf("rot_gid%0d", i),  32'(b0.grant_id), i % 4);
      chk($sformatf("rot_prio%0d", i), 32'(b0.prio), i % 4);
      chk("rot_nolock", 32'(b0.locked), 0);
      step();
    end
    b0.accept = 1'b0;

    // Sparse request from pointer 2
    b0.prio_load = 1'b1; b0.prio_in = 2'd2;
    step(); b0.prio_load = 1'b0; b0.requests = 4'b0011;
    #1 chk("sp_hold_g", 32'(b0.grants), 32'h1);
    chk("sp_hold_p", 32'(b0.prio), 2);
    step(); #1 chk("sp_hold_p2", 32'(b0.prio), 2);
    step(); b0.accept = 1'b1;
    #1 chk("sp_gid0", 32'(b0.grant_id), 0);
    step(); #1 chk("sp_prio1", 32'(b0.prio), 1);
    chk("sp_gid1", 32'(b0.grant_id), 1);
    step(); #1 chk("sp_prio2", 32'(b0.prio), 2);
    b0.accept = 1'b0;

    // SIZE=5: illegal pointer loads and wrap at SIZE-1
    b2.prio_load = 1'b1; b2.prio_in = 3'd4;
    step(); b2.prio_in = 3'd5;
    #1 chk("s5_load4", 32'(b2.prio), 4);
    step(); b2.prio_in = 3'd7;
    #1 chk("s5_ign5", 32'(b2.prio), 4);
    step(); b2.prio_load = 1'b0;
    #1 chk("s5_ign7", 32'(b2.prio), 4);
    b2.requests = 5'b11111; b2.accept = 1'b1;
    #1 chk("s5_gid4", 32'(b2.grant_id), 4);
    step(); b2.accept = 1'b0;
    #1 chk("s5_wrap", 32'(b2.prio), 0);

    // Lock, requester 1, three beats
    b1.requests = 4'b1010; b1.accept = 1'b1; b1.last = 1'b0;
    #1 chk("lk_b0_g", 32'(b1.grants), 32'h2);
    step(); #1 chk("lk_b1_g", 32'(b1.grants), 32'h2);
    chk("lk_b1_l", 32'(b1.locked), 1);
    chk("lk_b1_p", 32'(b1.prio), 0);
    step(); b1.last = 1'b1;
    #1 chk("lk_b2_g", 32'(b1.grants), 32'h2);
    chk("lk_b2_l", 32'(b1.locked), 1);
    step(); b1.accept = 1'b0; b1.last = 1'b0;
    #1 chk("lk_end_l", 32'(b1.locked), 0);
    chk("lk_end_p", 32'(b1.prio), 2);
    chk("lk_next", 32'(b1.grant_id), 3);

    // Lock held through a dropped request
    b1.prio_load = 1'b1; b1.prio_in = 2'd0;
    step(); b1.prio_load = 1'b0; b1.accept = 1'b1;
    #1 chk("dr_gid", 32'(b1.grant_id), 1);
    step(); b1.requests = 4'b1000;
    for (int i = 0; i < 2; i++) begin
      #1 chk("dr_grants", 32'(b1.grants), 0);
      chk("dr_gvld", 32'(b1.grant_valid), 0);
      chk("dr_locked", 32'(b1.locked), 1);
      step();
    end
    b1.requests = 4'b1010; b1.last = 1'b1;
    #1 chk("dr_back", 32'(b1.grants), 32'h2);
    step(); b1.accept = 1'b0; b1.last = 1'b0;
    #1 chk("dr_end_l", 32'(b1.locked), 0);
    chk("dr_end_p", 32'(b1.prio), 2);

    // prio_load colliding with lock exit from requester 2
    b1.requests = 4'b0100; b1.accept = 1'b1;
    #1 chk("pc_gid", 32'(b1.grant_id), 2);
    step(); b1.last = 1'b1; b1.prio_load = 1'b1; b1.prio_in = 2'd0;
    #1 chk("pc_l", 32'(b1.locked), 1);
    step(); b1.accept = 1'b0; b1.last = 1'b0; b1.prio_load = 1'b0;
    #1 chk("pc_prio", 32'(b1.prio), 0);
    chk("pc_unl", 32'(b1.locked), 0);

    // Async reset while locked to 3 at pointer 3
    b1.prio_load = 1'b1; b1.prio_in = 2'd3;
    step(); b1.prio_load = 1'b0; b1.requests = 4'b1000; b1.accept = 1'b1;
    step(); b1.accept = 1'b0;
    #1 chk("ar_pre_l", 32'(b1.locked), 1);
    chk("ar_pre_p", 32'(b1.prio), 3);
    #1 reset_n = 1'b0;
    #1 chk("ar_l", 32'(b1.locked), 0);
    chk("ar_p", 32'(b1.prio), 0);
    #1 reset_n = 1'b1;
    b1.requests = 4'b1001;
    #1 chk("ar_grant", 32'(b1.grants), 32'h1);

    step();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
